// File: rtl/gcd_job_sequencer_if.sv
// Stream and core-side signal bundle for the GCD job sequencer.
// The slave modport is the sequencer itself; master is its environment.
interface gcd_job_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             core_rst;
    logic             core_start;
    logic [WIDTH-1:0] core_data;
    logic             core_done;
    logic [WIDTH-1:0] core_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, out_ready, core_done, core_result,
        input  in_ready, core_rst, core_start, core_data, out_valid, out_gcd, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, core_done, core_result,
        output in_ready, core_rst, core_start, core_data, out_valid, out_gcd, out_err
    );
endinterface

// File: rtl/gcd_job_sequencer.sv
// Job sequencer feeding a subtractive GCD core: buffers operand pairs, loads the
// core over its shared operand bus, bypasses zero operands and aborts runaway jobs.
module gcd_job_sequencer #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 70000
) (
    input  logic               clk,
    input  logic               rst_n,
    gcd_job_sequencer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0]    PTR_ZERO    = {AW{1'b0}};
    localparam logic [AW-1:0]    PTR_ONE     = AW'(1);
    localparam logic [AW:0]      FCOUNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]      FCOUNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      FCOUNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]    CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
    localparam logic [CW-1:0]    CNT_MAX     = CW'(TIMEOUT);
    localparam logic [WIDTH-1:0] ZERO_W      = {WIDTH{1'b0}};

    typedef enum logic [2:0] {
        CRST   = 3'd0,
        IDLE   = 3'd1,
        LOAD_A = 3'd2,
        LOAD_B = 3'd3,
        RUN    = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] fifo_a_r [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_b_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [WIDTH-1:0] job_a_r;
    logic [WIDTH-1:0] job_b_r;
    logic [CW-1:0]    cnt_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_gcd_r;
    logic             out_err_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             job_ld_s;
    logic             res_ld_s;
    logic             res_err_s;
    logic [WIDTH-1:0] res_gcd_s;
    logic             slot_free_s;
    logic [WIDTH-1:0] head_a_s;
    logic [WIDTH-1:0] head_b_s;
    logic             head_zero_s;
    logic             core_rst_s;
    logic             core_start_s;
    logic [WIDTH-1:0] core_data_s;

    assign full_s      = (count_r == FCOUNT_FULL);
    assign empty_s     = (count_r == FCOUNT_ZERO);
    assign push_s      = bus.in_valid && !full_s;
    assign slot_free_s = !out_valid_r || bus.out_ready;
    assign head_a_s    = fifo_a_r[rd_ptr_r];
    assign head_b_s    = fifo_b_r[rd_ptr_r];
    assign head_zero_s = (head_a_s == ZERO_W) || (head_b_s == ZERO_W);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= CRST;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode plus pop and result-load strobes
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        job_ld_s    = 1'b0;
        res_ld_s    = 1'b0;
        res_err_s   = 1'b0;
        res_gcd_s   = ZERO_W;
        case (state_r)
            CRST: begin
                state_nxt_s = IDLE;
            end
            IDLE: begin
                if (empty_s) begin
                    state_nxt_s = IDLE;
                end else if (head_zero_s) begin
                    // gcd(x,0) = x and gcd(0,0) is reported as 0; the core would never finish
                    if (slot_free_s) begin
                        pop_s     = 1'b1;
                        res_ld_s  = 1'b1;
                        res_gcd_s = head_a_s | head_b_s;
                    end else begin
                        pop_s = 1'b0;
                    end
                end else begin
                    pop_s       = 1'b1;
                    job_ld_s    = 1'b1;
                    state_nxt_s = LOAD_A;
                end
            end
            LOAD_A: begin
                state_nxt_s = LOAD_B;
            end
            LOAD_B: begin
                state_nxt_s = RUN;
            end
            RUN: begin
                if (bus.core_done && slot_free_s) begin
                    res_ld_s    = 1'b1;
                    res_gcd_s   = bus.core_result;
                    state_nxt_s = CRST;
                end else if ((cnt_r == CNT_MAX) && slot_free_s) begin
                    res_ld_s    = 1'b1;
                    res_err_s   = 1'b1;
                    state_nxt_s = CRST;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = CRST;
            end
        endcase
    end

    // Core control and operand bus decoded from state
    always_comb begin
        core_rst_s   = 1'b0;
        core_start_s = 1'b0;
        core_data_s  = ZERO_W;
        case (state_r)
            CRST: begin
                core_rst_s = 1'b1;
            end
            LOAD_A: begin
                core_start_s = 1'b1;
                core_data_s  = job_a_r;
            end
            LOAD_B: begin
                core_data_s = job_b_r;
            end
            default: begin
                core_data_s = ZERO_W;
            end
        endcase
    end

    // Input pair FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_a_r[i] <= ZERO_W;
                fifo_b_r[i] <= ZERO_W;
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= FCOUNT_ZERO;
        end else begin
            if (push_s) begin
                fifo_a_r[wr_ptr_r] <= bus.in_a;
                fifo_b_r[wr_ptr_r] <= bus.in_b;
                wr_ptr_r           <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + FCOUNT_ONE;
                2'b01:   count_r <= count_r - FCOUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Operands of the job currently handed to the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_a_r <= ZERO_W;
            job_b_r <= ZERO_W;
        end else if (job_ld_s) begin
            job_a_r <= head_a_s;
            job_b_r <= head_b_s;
        end else begin
            job_a_r <= job_a_r;
            job_b_r <= job_b_r;
        end
    end

    // RUN cycle counter, saturating at the abort threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (state_r == LOAD_B) begin
            cnt_r <= CNT_ZERO;
        end else if ((state_r == RUN) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // One-entry result register; a load wins over a same-cycle drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_gcd_r   <= ZERO_W;
            out_err_r   <= 1'b0;
        end else if (res_ld_s) begin
            out_valid_r <= 1'b1;
            out_gcd_r   <= res_gcd_s;
            out_err_r   <= res_err_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready   = !full_s;
    assign bus.core_rst   = core_rst_s;
    assign bus.core_start = core_start_s;
    assign bus.core_data  = core_data_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_gcd    = out_gcd_r;
    assign bus.out_err    = out_err_r;
endmodule
